fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage that sits directly upstream of the CPU decode path. It owns the program counter, issues word requests to instruction memory over a valid/ready handshake, and buffers returned instructions in a small prefetch FIFO. It hands `{pc, instruction}` pairs to decode under a second valid/ready handshake. Branch/jump redirects flush in-flight and buffered instructions and restart fetch at the new address.

## Interface
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `FIFO_DEPTH`, 4: prefetch entries, power of two, 2..16. Also bounds outstanding requests.

- `clk`  in  1  the single clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high.
- `imem_req_valid`  out  1  request to instruction memory.
- `imem_req_addr`  out  32  word-aligned fetch address.
- `imem_req_ready`  in  1  memory accepts the request this cycle.
- `imem_resp_valid`  in  1  instruction word returned; in request order, ≥1 cycle after acceptance.
- `imem_resp_data`  in  32  instruction word.
- `redirect_valid`  in  1  branch/jump taken; one-cycle pulse.
- `redirect_pc`  in  32  new fetch address.
- `inst_valid`  out  1  FIFO head valid.
- `inst_pc`  out  32  address of head instruction.
- `inst_data`  out  32  head instruction.
- `inst_ready`  in  1  decode consumes head this cycle.
- `misalign_err`  out  1  sticky redirect-misalignment flag (see Configuration).

## Operation
- State: `fetch_pc`, `outstanding` counter (0..FIFO_DEPTH), `drop_cnt` counter, FIFO of `{pc, data}` with `count`, and a pc-tag queue that pairs each accepted request with its address.
- Request: `imem_req_valid = !halted && !redirect_valid && (count + outstanding) < FIFO_DEPTH`. `imem_req_addr = fetch_pc`. On `valid && ready`: `fetch_pc += 4` (mod 2^32, wraps 32'hFFFF_FFFC → 0), `outstanding += 1`, tag pushed.
- Response: if `drop_cnt > 0`, word discarded, `drop_cnt -= 1`, `outstanding -= 1`. Otherwise `{tag, data}` pushed to the FIFO and `outstanding -= 1`. Credit rule guarantees no overflow. Response with `outstanding == 0` is a protocol violation and is ignored.
- Pop: on `inst_valid && inst_ready`, head removed. Simultaneous push and pop when full or empty are legal; count stays unchanged.
- Redirect (highest priority): FIFO cleared, pop in the same cycle ignored, `drop_cnt <= outstanding` (minus any response consumed that cycle), `fetch_pc <= redirect_pc`, no request that cycle. A second redirect while draining reloads `drop_cnt` the same way.
- Reset mid-operation: all counters, FIFO, and `drop_cnt` cleared immediately. Stale responses after reset are caller's responsibility (memory is reset too).

## Timing
- Reset values: `imem_req_valid` 0 (asserts first cycle after reset release), `imem_req_addr` = RESET_PC, `inst_valid` 0, `inst_pc`/`inst_data` 0, `misalign_err` 0.
- Response to `inst_valid`: 1 cycle (registered FIFO; response at edge N visible at N+1).
- Redirect at cycle N: `inst_valid` 0 from N+1. Request for `redirect_pc` presented at N+1. First new instruction earliest N+3 with 1-cycle memory.
- Steady state: 1 instruction/cycle with 1-cycle memory and `inst_ready` held high.
- Outputs depend combinationally only on `redirect_valid` (request gating). Everything else is registered.

## Configuration
- `FETCH_MISALIGN_CHECK_EN` defined: redirect with `redirect_pc[1:0] != 0` sets `misalign_err` (sticky until reset) and `halted`. FIFO is flushed, no further requests are issued, and drained responses are still dropped.
- Undefined: `redirect_pc[1:0]` forced to 0. `misalign_err` tied 0. `halted` is never set.

## Test plan
- Reset release, 1-cycle memory returning `addr ^ 32'hA5A5_0000`, `inst_ready`=1 → requests 0,4,8,…; `inst_pc` 0,4,8 on consecutive cycles starting cycle 3.
- `inst_ready`=0 for 10 cycles → exactly FIFO_DEPTH (4) requests accepted, `imem_req_valid` 0 thereafter. Resume → entries 0,4,8,12 in order, no loss.
- Redirect to 32'h100 with 3 outstanding, 3-cycle memory latency → the 3 stale responses are dropped. First `inst_pc` is 32'h100, followed by 32'h104.
- `imem_req_ready` toggling 1/0 with random response latency 1–4 → decode stream strictly sequential, no duplicates.
- PC wrap: `redirect_pc`=32'hFFFF_FFF8 → `inst_pc` FFFF_FFF8, FFFF_FFFC, 0000_0000.
- With `FETCH_MISALIGN_CHECK_EN`: redirect to 32'h102 → `misalign_err`=1 next cycle, `inst_valid` 0, no requests until reset. Without the macro: fetch resumes at 32'h100.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the decode path.
// Owns the program counter, issues word fetches over a valid/ready request
// channel, tags each accepted request with its address, and buffers returned
// words in a small prefetch FIFO presented to decode as {pc, instruction}.
// Redirects flush buffered words and drop responses still in flight.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN -- when defined, a redirect
// to a non-word-aligned target sets a sticky misalign_err and halts fetch.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_data,
    input  logic        inst_ready,
    output logic        misalign_err
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);

    logic [31:0]   fetch_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] count;
    logic          started;
    logic          halted;

    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [31:0]   fifo_pc   [FIFO_DEPTH];
    logic [31:0]   fifo_data [FIFO_DEPTH];

    logic [AW-1:0] tag_rd;
    logic [AW-1:0] tag_wr;
    logic [31:0]   tag_q [FIFO_DEPTH];

    logic [CW:0]   in_flight;
    logic          req_fire;
    logic          resp_take;
    logic          resp_drop;
    logic          push;
    logic          pop;
    logic [31:0]   redirect_target;

    // Credits cover both buffered words and requests still in memory, so a
    // returning word always has a FIFO slot waiting for it.
    assign in_flight       = {1'b0, count} + {1'b0, outstanding};
    assign imem_req_valid  = started && !halted && !redirect_valid && (in_flight < DEPTH_W);
    assign imem_req_addr   = fetch_pc;
    assign req_fire        = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign resp_take       = imem_resp_valid && (outstanding != '0);
    assign resp_drop       = resp_take && (drop_cnt != '0);
    assign push            = resp_take && (drop_cnt == '0) && !redirect_valid;
    assign pop             = inst_valid && inst_ready && !redirect_valid;

    assign redirect_target = {redirect_pc[31:2], 2'b00};

    assign inst_valid      = (count != '0);
    assign inst_pc         = fifo_pc[rd_ptr];
    assign inst_data       = fifo_data[rd_ptr];

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misalign_hit;
    assign misalign_hit = redirect_valid && (redirect_pc[1:0] != 2'b00);

    // Latch a sticky error and stop fetching on a misaligned redirect target
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            misalign_err <= 1'b0;
            halted       <= 1'b0;
        end else if (misalign_hit) begin
            misalign_err <= 1'b1;
            halted       <= 1'b1;
        end
    end
`else
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];
    assign misalign_err         = 1'b0;
    assign halted               = 1'b0;
`endif

    // Request-side control: PC, in-flight count and stale-response drop count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            started     <= 1'b0;
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            started     <= 1'b1;
            outstanding <= outstanding + CW'(req_fire) - CW'(resp_take);
            if (redirect_valid) begin
                fetch_pc <= redirect_target;
                drop_cnt <= outstanding - CW'(resp_take);
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (resp_drop) begin
                    drop_cnt <= drop_cnt - CW'(1);
                end
            end
        end
    end

    // Address tag queue pairing each accepted request with its returning word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_rd <= '0;
            tag_wr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            if (req_fire) begin
                tag_q[tag_wr] <= fetch_pc;
                tag_wr        <= tag_wr + AW'(1);
            end
            if (resp_take) begin
                tag_rd <= tag_rd + AW'(1);
            end
        end
    end

    // Prefetch FIFO of {pc, instruction}; a redirect empties it at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_pc[i]   <= '0;
                fifo_data[i] <= '0;
            end
        end else if (redirect_valid) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_pc[wr_ptr]   <= tag_q[tag_rd];
                fifo_data[wr_ptr] <= imem_resp_data;
                wr_ptr            <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized scoreboard bench for fetch_unit.
// A memory model answers requests in order with programmable latency; the
// reference model predicts the decode stream as a plain sequence of word
// addresses restarted at every redirect.
`timescale 1ns/1ps
module tb_fetch_unit;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0000;
    localparam logic [31:0] KEY   = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst_pc;
    logic [31:0] inst_data;
    logic        inst_ready;
    logic        misalign_err;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .inst_valid      (inst_valid),
        .inst_pc         (inst_pc),
        .inst_data       (inst_data),
        .inst_ready      (inst_ready),
        .misalign_err    (misalign_err)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mem_req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    mem_req_t    mem_q[$];
    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          cur_lat = 1;
    int          last_due = 0;
    int          accept_cnt = 0;
    int          pop_cnt = 0;
    logic [31:0] model_pc = RPC;
    logic        model_halted = 1'b0;
    logic        prev_redirect = 1'b0;

    // Compare one observed value against the bench's expectation
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs and update the reference model on redirect
    task automatic applyStimulus(input logic rdy, input logic irdy, input logic redir,
                                 input logic [31:0] rpc, input int lat);
        @(negedge clk);
        imem_req_ready = rdy;
        inst_ready     = irdy;
        cur_lat        = lat;
        redirect_valid = redir;
        redirect_pc    = rpc;
        if (redir) begin
            exp_q.delete();
`ifdef FETCH_MISALIGN_CHECK_EN
            if (rpc[1:0] != 2'b00) model_halted = 1'b1;
`endif
            model_pc = {rpc[31:2], 2'b00};
        end
    endtask

    // Hold reset for a few cycles; memory and model restart with it
    task automatic applyReset(input int cycles);
        @(negedge clk);
        reset          = 1'b1;
        redirect_valid = 1'b0;
        imem_req_ready = 1'b0;
        inst_ready     = 1'b0;
        exp_q.delete();
        model_pc       = RPC;
        model_halted   = 1'b0;
        repeat (cycles) @(negedge clk);
        reset = 1'b0;
    endtask

    always @(negedge clk) cyc <= cyc + 1;

    // Memory responder: in-order words, addr ^ KEY, once due
    initial begin
        mem_req_t r;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        forever begin
            @(negedge clk);
            #1;
            if (reset) begin
                mem_q.delete();
                last_due        = 0;
                imem_resp_valid = 1'b0;
            end else if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
                r               = mem_q.pop_front();
                imem_resp_valid = 1'b1;
                imem_resp_data  = r.addr ^ KEY;
            end else begin
                imem_resp_valid = 1'b0;
                imem_resp_data  = $urandom;
            end
        end
    end

    // Request observer: checks request address and records accepted fetches
    initial begin
        int due;
        forever begin
            @(negedge clk);
            #2;
            if (!reset) begin
                if (redirect_valid) checkOutput("req_blocked_by_redirect", imem_req_valid, 0);
                if (model_halted)   checkOutput("req_while_halted", imem_req_valid, 0);
                if (imem_req_valid) checkOutput("req_addr", imem_req_addr, model_pc);
                if (imem_req_valid && imem_req_ready) begin
                    due = cyc + cur_lat;
                    if (due <= last_due) due = last_due + 1;
                    last_due = due;
                    mem_q.push_back('{imem_req_addr, due});
                    exp_q.push_back('{model_pc, model_pc ^ KEY});
                    model_pc = model_pc + 32'd4;
                    accept_cnt++;
                end
            end
        end
    end

    // Decode-side monitor: pops the scoreboard on every consumed instruction
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (reset) begin
                prev_redirect = 1'b0;
            end else begin
                if (prev_redirect) checkOutput("inst_valid_after_redirect", inst_valid, 0);
                if (inst_valid && inst_ready && !redirect_valid) begin
                    checkOutput("inst_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        checkOutput("inst_pc", inst_pc, e.pc);
                        checkOutput("inst_data", inst_data, e.data);
                    end
                    pop_cnt++;
                end
                prev_redirect = redirect_valid;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int first_valid;
        int p0;
        int a0;
        logic rdy;
        imem_req_ready = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        repeat (3) @(negedge clk);
        #4;
        checkOutput("rst_req_valid", imem_req_valid, 0);
        checkOutput("rst_req_addr", imem_req_addr, RPC);
        checkOutput("rst_inst_valid", inst_valid, 0);
        checkOutput("rst_inst_pc", inst_pc, 0);
        checkOutput("rst_inst_data", inst_data, 0);
        checkOutput("rst_misalign_err", misalign_err, 0);

        // Release reset with a 1-cycle memory and decode always ready
        @(negedge clk);
        reset          = 1'b0;
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        cur_lat        = 1;
        #4;
        checkOutput("req_valid_release_cycle", imem_req_valid, 0);
        first_valid = -1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            #4;
            if (i == 1) checkOutput("req_valid_first_cycle", imem_req_valid, 1);
            if (inst_valid && first_valid < 0) first_valid = i;
        end
        checkOutput("first_inst_cycle", first_valid, 3);

        p0 = pop_cnt;
        repeat (16) applyStimulus(1, 1, 0, 0, 1);
        #4;
        checkOutput("steady_throughput", pop_cnt - p0, 16);

        // Decode stalled: credits must cap accepted requests at the FIFO depth
        applyReset(2);
        a0 = accept_cnt;
        repeat (12) applyStimulus(1, 0, 0, 0, 1);
        #4;
        checkOutput("stall_accepts", accept_cnt - a0, DEPTH);
        checkOutput("stall_req_valid", imem_req_valid, 0);
        p0 = pop_cnt;
        repeat (10) applyStimulus(1, 1, 0, 0, 1);
        #4;
        checkOutput("stall_resume_pops", (pop_cnt - p0) >= DEPTH, 1);

        // Redirect with responses in flight on a 3-cycle memory
        repeat (10) applyStimulus(1, 1, 0, 0, 3);
        applyStimulus(1, 1, 1, 32'h0000_0100, 3);
        repeat (16) applyStimulus(1, 1, 0, 0, 3);

        // PC wrap across the top of the address space
        applyStimulus(1, 1, 1, 32'hFFFF_FFF8, 1);
        repeat (10) applyStimulus(1, 1, 0, 0, 1);

        // Misaligned redirect target
        applyStimulus(1, 1, 1, 32'h0000_0102, 1);
        applyStimulus(1, 1, 0, 0, 1);
        #4;
`ifdef FETCH_MISALIGN_CHECK_EN
        checkOutput("misalign_err_set", misalign_err, 1);
        checkOutput("misalign_inst_valid", inst_valid, 0);
        repeat (10) applyStimulus(1, 1, 0, 0, 1);
        #4;
        checkOutput("misalign_err_sticky", misalign_err, 1);
        applyReset(2);
        #4;
        checkOutput("misalign_err_reset", misalign_err, 0);
`else
        checkOutput("misalign_err_tied", misalign_err, 0);
        repeat (10) applyStimulus(1, 1, 0, 0, 1);
`endif

        // Request ready toggling with random latency
        for (int i = 0; i < 100; i++) begin
            applyStimulus(i[0], 1, 0, 0, $urandom_range(1, 4));
        end

        // Fully random traffic with occasional redirects and one mid-run reset
        for (int i = 0; i < 400; i++) begin
            if (i == 200) applyReset(2);
            rdy = ($urandom_range(0, 3) != 0);
            applyStimulus(rdy, ($urandom_range(0, 3) != 0), ($urandom_range(0, 49) == 0),
                          32'h0000_1000 + ($urandom_range(0, 255) << 2), $urandom_range(1, 4));
        end

        // Drain: stop new requests and let every accepted fetch reach decode
        repeat (30) applyStimulus(0, 1, 0, 0, 1);
        #4;
        checkOutput("drain_scoreboard_empty", exp_q.size(), 0);
        checkOutput("drain_memory_empty", mem_q.size(), 0);
        checkOutput("drain_inst_valid", inst_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
